// File: rtl/vocoder_stream_scheduler.sv
// Stream sequencer around the vocoder core: pairs carrier/modulator ADC samples, writes IFFT
// output bit-reversed into a ping-pong buffer and paces completed frames out to the DAC.
module vocoder_stream_scheduler #(
  parameter int         LOG2N   = 10,
  parameter int         SW      = 12,
  parameter int         OW      = 16,
  parameter int         DAC_DIV = 64,
  parameter logic [2:0] CARR_CH = 3'd0,
  parameter logic [2:0] MOD_CH  = 3'd7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SW-1:0]    adc_result,
  input  logic             adc_data_valid,
  output logic [2:0]       adc_chan,
  output logic [SW-1:0]    carr_re,
  output logic [SW-1:0]    mod_re,
  output logic             core_valid_in,
  input  logic             core_valid_out,
  input  logic [OW-1:0]    core_y_re,
  output logic             buf_wr_en,
  output logic [LOG2N:0]   buf_wr_addr,
  output logic [OW-1:0]    buf_wr_data,
  output logic [LOG2N:0]   buf_rd_addr,
  input  logic [OW-1:0]    buf_rd_data,
  output logic [OW-1:0]    dac_data,
  output logic             dac_strobe,
  output logic             overrun,
  output logic             underrun
);

  localparam int                DW       = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;
  localparam logic [LOG2N-1:0]  IDX_LAST = '1;
  localparam logic [DW-1:0]     DIV_LAST = DW'(DAC_DIV - 1);

  typedef enum logic { CARR_WAIT, MOD_WAIT } adc_st_t;
  typedef enum logic { P_IDLE, P_PLAY } pb_st_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  adc_st_t          r_adc_st;
  logic [2:0]       r_adc_chan;
  logic [SW-1:0]    r_carr;
  logic [SW-1:0]    r_mod;
  logic             r_core_vld;

  logic             r_wr_en;
  logic [LOG2N:0]   r_wr_addr;
  logic [OW-1:0]    r_wr_data;
  logic [LOG2N-1:0] r_wcnt;
  logic             r_wbank;
  logic             r_overrun;
  logic [1:0]       r_full;

  pb_st_t           r_pb_st;
  logic             r_rbank;
  logic [LOG2N-1:0] r_rcnt;
  logic [DW-1:0]    r_div;
  logic [LOG2N:0]   r_rd_addr;
  logic             r_underrun;
  logic             r_vld_p0;
  logic             r_vld_p1;
  logic [OW-1:0]    r_dac_data;
  logic             r_dac_strobe;

  logic             w_wr_last;
  logic             w_issue;
  logic             w_rd_last;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic             w_next_ready;

  assign w_wr_last    = core_valid_out && (r_wcnt == IDX_LAST);
  assign w_issue      = (r_pb_st == P_PLAY) && (r_div == '0);
  assign w_rd_last    = w_issue && (r_rcnt == IDX_LAST);
  assign w_full_set   = w_wr_last ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_clr   = w_rd_last ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;
  // A frame finishing in the same cycle as the release still counts as ready.
  assign w_next_ready = r_full[~r_rbank] | w_full_set[~r_rbank];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_adc_st   <= CARR_WAIT;
      r_adc_chan <= CARR_CH;
      r_carr     <= '0;
      r_mod      <= '0;
      r_core_vld <= 1'b0;
    end else begin
      r_core_vld <= 1'b0;
      if (adc_data_valid) begin
        if (r_adc_st == CARR_WAIT) begin
          r_carr     <= adc_result;
          r_adc_st   <= MOD_WAIT;
          r_adc_chan <= MOD_CH;
        end else begin
          r_mod      <= adc_result;
          r_core_vld <= 1'b1;
          r_adc_st   <= CARR_WAIT;
          r_adc_chan <= CARR_CH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wcnt    <= '0;
      r_wbank   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_en <= core_valid_out;
      if (core_valid_out) begin
        r_wr_data <= core_y_re;
        r_wr_addr <= {r_wbank, bitrev(r_wcnt)};
        r_wcnt    <= r_wcnt + 1'b1;
        // Finishing a frame into a bank that was never released means playback lost data.
        if (w_wr_last) begin
          r_wbank <= ~r_wbank;
          if (r_full[r_wbank]) r_overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_full <= 2'b00;
    else          r_full <= (r_full & ~w_full_clr) | w_full_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pb_st    <= P_IDLE;
      r_rbank    <= 1'b0;
      r_rcnt     <= '0;
      r_div      <= '0;
      r_rd_addr  <= '0;
      r_underrun <= 1'b0;
    end else begin
      case (r_pb_st)
        P_IDLE: begin
          if (r_full[r_rbank]) begin
            r_pb_st <= P_PLAY;
            r_rcnt  <= '0;
            r_div   <= '0;
          end
        end
        default: begin
          r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
          if (w_issue) begin
            r_rd_addr <= {r_rbank, r_rcnt};
            r_rcnt    <= r_rcnt + 1'b1;
            if (w_rd_last) begin
              r_rbank <= ~r_rbank;
              if (!w_next_ready) begin
                r_pb_st    <= P_IDLE;
                r_underrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // p0: address issued to RAM; p1: RAM holds read data; capture into dac_data next edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_dac_strobe <= 1'b0;
      r_dac_data   <= '0;
    end else begin
      r_vld_p0     <= w_issue;
      r_vld_p1     <= r_vld_p0;
      r_dac_strobe <= r_vld_p1;
      if (r_vld_p1) r_dac_data <= buf_rd_data;
    end
  end

  assign adc_chan      = r_adc_chan;
  assign carr_re       = r_carr;
  assign mod_re        = r_mod;
  assign core_valid_in = r_core_vld;
  assign buf_wr_en     = r_wr_en;
  assign buf_wr_addr   = r_wr_addr;
  assign buf_wr_data   = r_wr_data;
  assign buf_rd_addr   = r_rd_addr;
  assign dac_data      = r_dac_data;
  assign dac_strobe    = r_dac_strobe;
  assign overrun       = r_overrun;
  assign underrun      = r_underrun;

endmodule
